// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
//
// Command sequencer that sits directly in front of a WIDTH-bit control-line
// register. It takes one operation per valid/ready handshake and turns it
// into a one-hot stream of control lines (cl/ld/inc/dec/sr/ir/sl/il). Ops
// that take a count repeat for cmd_cnt+1 cycles. A one-cycle done pulse
// follows each command that completes normally.
//
// Optional feature macro: REG_SEQ_ROTATE_EN
//   defined   : op 7 is ROR. It asserts sr, and ir follows reg_q[0].
//   undefined : op 7 behaves as NOP. cmd_cnt is ignored for it.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (IDLE only)
//   cmd_op     0 NOP,1 CLR,2 LOAD,3 INC,4 DEC,5 SHR,6 SHL,7 ROR
//   cmd_cnt    repeat count minus one (INC/DEC/SHR/SHL/ROR)
//   cmd_data   LOAD value
//   cmd_abort  abort of the executing command
//   reg_q      register contents fed back (ROR serial source)
//   cl..il     register control lines
//   reg_in     parallel-load data, only non-zero while ld is high
//   busy       high in EXEC and DONE
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module reg_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_abort,
    input  logic [WIDTH-1:0] reg_q,
    output logic             cl,
    output logic             ld,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             ir,
    output logic             sl,
    output logic             il,
    output logic [WIDTH-1:0] reg_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             op_counted;

    // Only the upper reg_q bits (and all of them without rotate) are unused.
    logic unused_reg_q;
    assign unused_reg_q = ^reg_q;

    // Decides which ops honour cmd_cnt. All other ops run for one EXEC cycle.
    always_comb begin
        op_counted = 1'b0;
        case (cmd_op)
            OP_INC, OP_DEC, OP_SHR, OP_SHL: op_counted = 1'b1;
`ifdef REG_SEQ_ROTATE_EN
            OP_ROR:                         op_counted = 1'b1;
`endif
            default:                        op_counted = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic. The command fields are latched at the handshake.
    // From then on the controls come from registered state only.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    rem_d   = op_counted ? cmd_cnt : '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cmd_abort) begin
                    state_d = S_IDLE;
                end else if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control decode. cmd_abort masks every line within the same cycle.
    // An async reset forces IDLE, so the lines drop without waiting for a clock edge.
    always_comb begin
        cl = 1'b0;
        ld = 1'b0;
        inc = 1'b0;
        dec = 1'b0;
        sr = 1'b0;
        ir = 1'b0;
        sl = 1'b0;
        il = 1'b0;
        if (state_q == S_EXEC && !cmd_abort) begin
            case (op_q)
                OP_CLR:  cl  = 1'b1;
                OP_LOAD: ld  = 1'b1;
                OP_INC:  inc = 1'b1;
                OP_DEC:  dec = 1'b1;
                OP_SHR:  sr  = 1'b1;
                OP_SHL:  sl  = 1'b1;
`ifdef REG_SEQ_ROTATE_EN
                OP_ROR: begin
                    sr = 1'b1;
                    ir = reg_q[0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign reg_in    = ld ? data_q : '0;
    assign cmd_ready = (state_q == S_IDLE) && rst_n;
    assign busy      = (state_q == S_EXEC) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_op_sequencer
//
// Directed bench for reg_op_sequencer. A small behavioural 4-bit register
// is driven by the control lines and feeds reg_q back, as the real register
// would. Inputs change on the falling edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_reg_op_sequencer;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    // Control vector bit values: {cl,ld,inc,dec,sr,ir,sl,il}
    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_LD   = 8'h40;
    localparam logic [7:0] C_INC  = 8'h20;
    localparam logic [7:0] C_DEC  = 8'h10;
    localparam logic [7:0] C_SR   = 8'h08;
    localparam logic [7:0] C_SRIR = 8'h0C;
    localparam logic [7:0] C_SL   = 8'h02;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [2:0] cmd_cnt = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       cmd_abort = 1'b0;
    logic [3:0] reg_q = 4'd0;
    logic       cl, ld, inc, dec, sr, ir, sl, il;
    logic [3:0] reg_in;
    logic       busy, done;
    logic [7:0] ctl;

    int tests_run = 0;
    int tests_failed = 0;

    assign ctl = {cl, ld, inc, dec, sr, ir, sl, il};

    always #5 clk = ~clk;

    reg_op_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
        .cmd_abort(cmd_abort), .reg_q(reg_q),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .sr(sr), .ir(ir), .sl(sl), .il(il),
        .reg_in(reg_in), .busy(busy), .done(done)
    );

    // Behavioural stand-in for the controlled register. It is not reset, so a
    // partial result survives a sequencer reset.
    always @(posedge clk) begin
        if (cl)       reg_q <= 4'h0;
        else if (ld)  reg_q <= reg_in;
        else if (inc) reg_q <= reg_q + 4'h1;
        else if (dec) reg_q <= reg_q - 4'h1;
        else if (sr)  reg_q <= {ir, reg_q[3:1]};
        else if (sl)  reg_q <= {reg_q[2:0], il};
    end

    // Waits for cmd_ready and presents one command for a single handshake.
    // Returns at the falling edge of the first EXEC cycle, with cmd_valid low.
    task automatic issue(input logic [2:0] op, input logic [2:0] cnt,
                         input logic [3:0] data);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (!cmd_ready) begin
            tests_failed++;
            $display("[TB] FAIL issue_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_op = op;
        cmd_cnt = cnt;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic preload(input logic [3:0] value);
        issue(OP_LOAD, 3'd0, value);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if (ctl !== C_NONE || reg_in !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: ctl=%h reg_in=%h busy=%b done=%b required 00/0/0/0",
                     ctl, reg_in, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_load();
        issue(OP_LOAD, 3'd0, 4'hA);
        tests_run++;
        if (ctl !== C_LD || reg_in !== 4'hA || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_exec: ctl=%h reg_in=%h busy=%b required 40/a/1", ctl, reg_in, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || ctl !== C_NONE || reg_q !== 4'hA || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_done: done=%b ctl=%h reg_q=%h ready=%b required 1/00/a/0",
                     done, ctl, reg_q, cmd_ready);
        end
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_idle: ready=%b done=%b busy=%b required 1/0/0", cmd_ready, done, busy);
        end
    endtask

    task automatic test_inc_wrap();
        logic [3:0] exp_q [3] = '{4'hE, 4'hF, 4'h0};
        preload(4'hE);
        issue(OP_INC, 3'd2, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (ctl !== C_INC || reg_q !== exp_q[k] || done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL inc_cycle%0d: ctl=%h reg_q=%h done=%b required 20/%h/0",
                         k, ctl, reg_q, done, exp_q[k]);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || ctl !== C_NONE || reg_q !== 4'h1) begin
            tests_failed++;
            $display("[TB] FAIL inc_done: done=%b ctl=%h reg_q=%h required 1/00/1", done, ctl, reg_q);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL inc_single_done: done=%b required 0", done);
        end
    endtask

    task automatic test_shift();
        preload(4'h9);
        issue(OP_SHR, 3'd0, 4'h0);
        tests_run++;
        if (ctl !== C_SR) begin
            tests_failed++;
            $display("[TB] FAIL shr_ctl: ctl=%h required 08", ctl);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || reg_q !== 4'h4) begin
            tests_failed++;
            $display("[TB] FAIL shr_done: done=%b reg_q=%h required 1/4", done, reg_q);
        end
        issue(OP_SHL, 3'd0, 4'h0);
        tests_run++;
        if (ctl !== C_SL) begin
            tests_failed++;
            $display("[TB] FAIL shl_ctl: ctl=%h required 02", ctl);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || reg_q !== 4'h8) begin
            tests_failed++;
            $display("[TB] FAIL shl_done: done=%b reg_q=%h required 1/8", done, reg_q);
        end
    endtask

    task automatic test_ror();
        preload(4'h3);
        issue(OP_ROR, 3'd1, 4'h0);
`ifdef REG_SEQ_ROTATE_EN
        tests_run++;
        if (ctl !== C_SRIR || reg_q !== 4'h3) begin
            tests_failed++;
            $display("[TB] FAIL ror_cycle0: ctl=%h reg_q=%h required 0c/3", ctl, reg_q);
        end
        @(negedge clk);
        tests_run++;
        if (ctl !== C_SRIR || reg_q !== 4'h9) begin
            tests_failed++;
            $display("[TB] FAIL ror_cycle1: ctl=%h reg_q=%h required 0c/9", ctl, reg_q);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || reg_q !== 4'hC) begin
            tests_failed++;
            $display("[TB] FAIL ror_done: done=%b reg_q=%h required 1/c", done, reg_q);
        end
`else
        tests_run++;
        if (ctl !== C_NONE || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ror_as_nop: ctl=%h busy=%b required 00/1", ctl, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || reg_q !== 4'h3) begin
            tests_failed++;
            $display("[TB] FAIL ror_nop_done: done=%b reg_q=%h required 1/3", done, reg_q);
        end
`endif
    endtask

    task automatic test_nop();
        issue(OP_NOP, 3'd5, 4'h7);
        tests_run++;
        if (ctl !== C_NONE || reg_in !== 4'h0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL nop_exec: ctl=%h reg_in=%h busy=%b required 00/0/1", ctl, reg_in, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL nop_done: done=%b required 1", done);
        end
    endtask

    task automatic test_abort();
        preload(4'h0);
        issue(OP_INC, 3'd7, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (ctl !== C_INC) begin
                tests_failed++;
                $display("[TB] FAIL abort_pre%0d: ctl=%h required 20", k, ctl);
            end
            @(negedge clk);
        end
        cmd_abort = 1'b1;
        #1;
        tests_run++;
        if (ctl !== C_NONE) begin
            tests_failed++;
            $display("[TB] FAIL abort_mask: ctl=%h required 00", ctl);
        end
        @(negedge clk);
        cmd_abort = 1'b0;
        tests_run++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || reg_q !== 4'h3 || ctl !== C_NONE) begin
            tests_failed++;
            $display("[TB] FAIL abort_after: ready=%b done=%b reg_q=%h ctl=%h required 1/0/3/00",
                     cmd_ready, done, reg_q, ctl);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || reg_q !== 4'h3) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_done: done=%b reg_q=%h required 0/3", done, reg_q);
        end
    endtask

    task automatic test_reset_mid_exec();
        preload(4'h6);
        issue(OP_DEC, 3'd5, 4'h0);
        tests_run++;
        if (ctl !== C_DEC) begin
            tests_failed++;
            $display("[TB] FAIL dec_ctl: ctl=%h required 10", ctl);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ctl !== C_NONE || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_drop: ctl=%h busy=%b done=%b required 00/0/0", ctl, busy, done);
        end
        @(negedge clk);
        tests_run++;
        if (reg_q !== 4'h5) begin
            tests_failed++;
            $display("[TB] FAIL midreset_partial: reg_q=%h required 5", reg_q);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_ready: cmd_ready=%b required 1", cmd_ready);
        end
        issue(OP_LOAD, 3'd0, 4'hB);
        tests_run++;
        if (ctl !== C_LD || reg_in !== 4'hB) begin
            tests_failed++;
            $display("[TB] FAIL midreset_load: ctl=%h reg_in=%h required 40/b", ctl, reg_in);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || reg_q !== 4'hB) begin
            tests_failed++;
            $display("[TB] FAIL midreset_load_done: done=%b reg_q=%h required 1/b", done, reg_q);
        end
    endtask

    // A command held valid while the sequencer is busy must not be taken until
    // the first IDLE cycle (N+3 after the first handshake).
    task automatic test_back_to_back();
        @(negedge clk);
        cmd_op = OP_LOAD;
        cmd_cnt = 3'd0;
        cmd_data = 4'h2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_data = 4'hD;
        tests_run++;
        if (ctl !== C_LD || reg_in !== 4'h2 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: ctl=%h reg_in=%h ready=%b required 40/2/0", ctl, reg_in, cmd_ready);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || reg_q !== 4'h2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_done: done=%b ready=%b reg_q=%h required 1/0/2", done, cmd_ready, reg_q);
        end
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || ctl !== C_NONE) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle: ready=%b ctl=%h required 1/00", cmd_ready, ctl);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++;
        if (ctl !== C_LD || reg_in !== 4'hD) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: ctl=%h reg_in=%h required 40/d", ctl, reg_in);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || reg_q !== 4'hD) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_done: done=%b reg_q=%h required 1/d", done, reg_q);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_inc_wrap();
        test_shift();
        test_ror();
        test_nop();
        test_abort();
        test_reset_mid_exec();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
